// File: rtl/f_pc_fd_stage.sv
// ---------------------------------------------------------------------------
// f_pc_fd_stage
//   Fetch-side PC register, next-PC selection and F/D pipeline register.
//   Redirects (branch / j / jal / jr) are resolved from the instruction held
//   in D. There is no flush, so the delay-slot instruction (fetched while the
//   redirecting instruction sits in D) always enters D.
//
// Parameters
//   PC_RESET : PC after reset and the instruction-memory base address.
//   IM_AW    : instruction-memory word-address width.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   stall         in   freeze PC and F/D register
//   npc_op        in   00 seq, 01 branch, 10 j/jal, 11 jr
//   cmp_jump      in   branch condition from the D comparator
//   rs_data       in   forwarded GPR[rs], jr target
//   im_instr      in   instruction read from IM at im_addr
//   im_addr       out  IM word address, relative to PC_RESET
//   F_pc          out  current fetch PC
//   F_pc_misalign out  F_pc not word aligned
//   D_instr       out  instruction in D
//   D_pc          out  PC of D_instr
//   D_pc8         out  D_pc + 8 (link value)
//   D_valid       out  D holds a fetched instruction
// ---------------------------------------------------------------------------
module f_pc_fd_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [1:0]       npc_op,
  input  logic             cmp_jump,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      im_instr,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      F_pc,
  output logic             F_pc_misalign,
  output logic [31:0]      D_instr,
  output logic [31:0]      D_pc,
  output logic [31:0]      D_pc8,
  output logic             D_valid
);

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] next_pc;
  logic [31:0] im_off;

  assign seq_pc    = F_pc + 32'd4;
  // Offset is sign-extended before the word shift so negative branches work.
  assign br_off    = {{14{D_instr[15]}}, D_instr[15:0], 2'b00};
  assign br_target = D_pc + 32'd4 + br_off;
  assign j_target  = {D_pc[31:28], D_instr[25:0], 2'b00};

  // The reset bubble in D carries no real instruction, so its control
  // inputs are ignored until the first fetched instruction arrives.
  always_comb begin
    next_pc = seq_pc;
    if (D_valid) begin
      case (npc_op)
        NPC_BRANCH: next_pc = cmp_jump ? br_target : seq_pc;
        NPC_JUMP:   next_pc = j_target;
        NPC_JR:     next_pc = rs_data;
        NPC_SEQ:    next_pc = seq_pc;
        default:    next_pc = seq_pc;
      endcase
    end
  end

  // Holding D during a stall keeps any pending redirect alive; it is taken
  // on the first unstalled edge, and only once since D then advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      F_pc    <= PC_RESET;
      D_instr <= 32'h0000_0000;
      D_pc    <= PC_RESET;
      D_valid <= 1'b0;
    end else if (!stall) begin
      F_pc    <= next_pc;
      D_instr <= im_instr;
      D_pc    <= F_pc;
      D_valid <= 1'b1;
    end
  end

  // Out-of-range PCs simply wrap in the truncated word address.
  assign im_off        = F_pc - PC_RESET;
  assign im_addr       = im_off[IM_AW+1:2];
  assign F_pc_misalign = |F_pc[1:0];
  assign D_pc8         = D_pc + 32'd8;

endmodule

// File: tb/tb_f_pc_fd_stage.sv
module tb_f_pc_fd_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic [1:0]  npc_op;
  logic        cmp_jump;
  logic [31:0] rs_data;
  logic [31:0] im_instr;
  logic [11:0] im_addr;
  logic [31:0] F_pc;
  logic        F_pc_misalign;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc8;
  logic        D_valid;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_fpc;
  logic [31:0] m_dinstr;
  logic [31:0] m_dpc;
  logic        m_dvalid;

  f_pc_fd_stage #(.PC_RESET(32'h0000_3000), .IM_AW(12)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .npc_op(npc_op),
    .cmp_jump(cmp_jump), .rs_data(rs_data), .im_instr(im_instr),
    .im_addr(im_addr), .F_pc(F_pc), .F_pc_misalign(F_pc_misalign),
    .D_instr(D_instr), .D_pc(D_pc), .D_pc8(D_pc8), .D_valid(D_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_fpc    = 32'h0000_3000;
    m_dinstr = 32'h0;
    m_dpc    = 32'h0000_3000;
    m_dvalid = 1'b0;
  endtask

  function automatic logic [11:0] exp_im_addr(input logic [31:0] pc);
    logic [31:0] words;
    words = (pc - 32'h0000_3000) / 4;
    return 12'(words % 4096);
  endfunction

  // Drive one cycle of inputs, advance to 1 time unit past the rising edge,
  // and step the reference model with the architectural rules.
  task automatic drive_edge(input logic st, input logic [1:0] op, input logic cj,
                            input logic [31:0] rs, input logic [31:0] im);
    logic [31:0] nf;
    int off;
    stall = st; npc_op = op; cmp_jump = cj; rs_data = rs; im_instr = im;
    nf = m_fpc + 32'd4;
    if (m_dvalid) begin
      if (op == 2'd1 && cj) begin
        off = int'($signed(m_dinstr[15:0]));
        nf  = m_dpc + 32'd4 + 32'(off * 4);
      end else if (op == 2'd2) begin
        nf = (m_dpc & 32'hF000_0000) | ((m_dinstr & 32'h03FF_FFFF) << 2);
      end else if (op == 2'd3) begin
        nf = rs;
      end
    end
    @(posedge clk);
    #1;
    if (!st) begin
      m_dinstr = im;
      m_dpc    = m_fpc;
      m_fpc    = nf;
      m_dvalid = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0; npc_op = 2'd0; cmp_jump = 1'b0; rs_data = 32'h0; im_instr = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (F_pc !== 32'h3000) begin failures++; $display("FAIL reset_fpc got=%h exp=%h", F_pc, 32'h3000); end
    checks++; if (im_addr !== 12'h0) begin failures++; $display("FAIL reset_imaddr got=%h exp=0", im_addr); end
    checks++; if (D_valid !== 1'b0) begin failures++; $display("FAIL reset_dvalid got=%b exp=0", D_valid); end
    checks++; if (D_instr !== 32'h0 || D_pc !== 32'h3000) begin failures++; $display("FAIL reset_d got=%h/%h exp=0/3000", D_instr, D_pc); end
    // redirect request ignored while D holds the reset bubble
    drive_edge(1'b0, 2'd3, 1'b1, 32'h0000_5000, 32'h1234_5678);
    checks++; if (F_pc !== 32'h3004) begin failures++; $display("FAIL edge1_fpc got=%h exp=3004", F_pc); end
    checks++; if (D_pc !== 32'h3000 || D_valid !== 1'b1) begin failures++; $display("FAIL edge1_d got=%h/%b exp=3000/1", D_pc, D_valid); end
    checks++; if (D_instr !== 32'h1234_5678) begin failures++; $display("FAIL edge1_instr got=%h exp=12345678", D_instr); end
  endtask

  task automatic test_jump();
    do_reset();
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0800_0C10);
    checks++; if (D_pc8 !== 32'h3008) begin failures++; $display("FAIL j_pc8 got=%h exp=3008", D_pc8); end
    drive_edge(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    checks++; if (F_pc !== 32'h3040) begin failures++; $display("FAIL j_target got=%h exp=3040", F_pc); end
    checks++; if (D_pc !== 32'h3004) begin failures++; $display("FAIL j_delay_slot got=%h exp=3004", D_pc); end
  endtask

  task automatic test_branch();
    // taken: D_pc=0x3008, beq +3
    do_reset();
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h1000_0003);
    checks++; if (D_pc !== 32'h3008) begin failures++; $display("FAIL beq_setup got=%h exp=3008", D_pc); end
    drive_edge(1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
    checks++; if (F_pc !== 32'h3018) begin failures++; $display("FAIL beq_taken got=%h exp=3018", F_pc); end
    // not taken
    do_reset();
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h1000_0003);
    drive_edge(1'b0, 2'd1, 1'b0, 32'h0, 32'h0);
    checks++; if (F_pc !== 32'h3010) begin failures++; $display("FAIL beq_not_taken got=%h exp=3010", F_pc); end
    // imm = -1 -> target is the branch itself
    do_reset();
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h1000_FFFF);
    drive_edge(1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
    checks++; if (F_pc !== 32'h3004) begin failures++; $display("FAIL beq_neg got=%h exp=3004", F_pc); end
  endtask

  task automatic test_jr();
    do_reset();
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive_edge(1'b0, 2'd3, 1'b0, 32'h0000_3104, 32'h0);
    checks++; if (F_pc !== 32'h3104 || F_pc_misalign !== 1'b0) begin failures++; $display("FAIL jr_aligned got=%h/%b exp=3104/0", F_pc, F_pc_misalign); end
    checks++; if (im_addr !== 12'h041) begin failures++; $display("FAIL jr_imaddr got=%h exp=041", im_addr); end
    drive_edge(1'b0, 2'd3, 1'b0, 32'h0000_3102, 32'h0);
    checks++; if (F_pc !== 32'h3102 || F_pc_misalign !== 1'b1) begin failures++; $display("FAIL jr_misalign got=%h/%b exp=3102/1", F_pc, F_pc_misalign); end
    // wrap: 0xFFFF_FFFC + 4 -> 0
    drive_edge(1'b0, 2'd3, 1'b0, 32'hFFFF_FFFC, 32'h0);
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    checks++; if (F_pc !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", F_pc); end
    checks++; if (im_addr !== 12'h400) begin failures++; $display("FAIL wrap_imaddr got=%h exp=400", im_addr); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h1000_0003);
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 2'd1, 1'b1, 32'h0, 32'hDEAD_BEEF);
      checks++;
      if (F_pc !== 32'h300C || D_pc !== 32'h3008 || D_instr !== 32'h1000_0003) begin
        failures++; $display("FAIL stall_hold%0d got=%h/%h/%h exp=300c/3008/10000003", i, F_pc, D_pc, D_instr);
      end
    end
    drive_edge(1'b0, 2'd1, 1'b1, 32'h0, 32'h0000_0000);
    checks++; if (F_pc !== 32'h3018 || D_pc !== 32'h300C) begin failures++; $display("FAIL stall_release got=%h/%h exp=3018/300c", F_pc, D_pc); end
    drive_edge(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    checks++; if (F_pc !== 32'h301C) begin failures++; $display("FAIL redirect_once got=%h exp=301c", F_pc); end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] rs;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      op = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 16383)));
      drive_edge(($urandom_range(0, 3) == 0), op, 1'($urandom), rs, $urandom);
      checks++;
      if (F_pc !== m_fpc || im_addr !== exp_im_addr(m_fpc) || F_pc_misalign !== (m_fpc % 4 != 0)) begin
        failures++; $display("FAIL rand_f n=%0d got=%h/%h/%b exp=%h/%h", n, F_pc, im_addr, F_pc_misalign, m_fpc, exp_im_addr(m_fpc));
      end
      checks++;
      if (D_instr !== m_dinstr || D_pc !== m_dpc || D_pc8 !== m_dpc + 32'd8 || D_valid !== m_dvalid) begin
        failures++; $display("FAIL rand_d n=%0d got=%h/%h/%h/%b exp=%h/%h/%b", n, D_instr, D_pc, D_pc8, D_valid, m_dinstr, m_dpc, m_dvalid);
      end
      if (n == 200) begin
        // asynchronous reset pulse between edges
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (F_pc !== 32'h3000 || D_pc !== 32'h3000 || D_instr !== 32'h0 || D_valid !== 1'b0 || im_addr !== 12'h0) begin
          failures++; $display("FAIL async_reset got=%h/%h/%h/%b exp=3000/3000/0/0", F_pc, D_pc, D_instr, D_valid);
        end
        #1 reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    stall = 1'b0; npc_op = 2'd0; cmp_jump = 1'b0; rs_data = 32'h0; im_instr = 32'h0;
    model_reset();
    test_reset();
    test_jump();
    test_branch();
    test_jr();
    test_stall_redirect();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
